// File: rtl/bus_mux_pipe.sv
// Registered N:1 data mux with valid/ready handshake and sticky illegal-select flag.
// Define BUS_MUX_PIPE_ERR_CNT_EN to add an 8-bit saturating illegal-select counter (err_cnt).
module bus_mux_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 5,
    parameter int unsigned SEL_W  = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    input  logic                    err_clr
`ifdef BUS_MUX_PIPE_ERR_CNT_EN
    ,
    output logic [7:0]              err_cnt
`endif
);

    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;
    logic [WIDTH-1:0] mux_c;
    logic             accept;
    logic             sel_legal;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign sel_legal = 32'(sel) < NUM_IN;

    // Out-of-range selects fall through to zero.
    always_comb begin
        mux_c = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (32'(sel) == i) begin
                mux_c = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        result_d    = result_q;
        out_valid_d = out_valid_q;
        sel_err_d   = sel_err_q;
        if (accept) begin
            result_d    = mux_c;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // An illegal accept outranks a same-cycle clear.
        if (accept && !sel_legal) begin
            sel_err_d = 1'b1;
        end else if (err_clr) begin
            sel_err_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

`ifdef BUS_MUX_PIPE_ERR_CNT_EN
    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating count; a clear coinciding with an illegal accept leaves a count of one.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && !sel_legal) begin
            if (err_clr) begin
                err_cnt_d = CNT_W'(1);
            end else if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end else if (err_clr) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/bus_mux_pipe.md
BUS_MUX_PIPE -- requirements
Module: bus_mux_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the data bit width per input (range 1..32).
REQ-002 SHALL have parameter NUM_IN, default 5, meaning the number of data inputs (range 2..16).
REQ-003 SHALL have parameter SEL_W, default 3, meaning the select width; SEL_W >= ceil(log2(NUM_IN)).
REQ-004 SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port data_in, input, NUM_IN*WIDTH bits: input i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port sel, input, SEL_W bits: the input index, sampled with in_valid.
REQ-008 SHALL have port in_valid, input, 1 bit: upstream offers data_in/sel.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts this cycle.
REQ-010 SHALL have port result, output, WIDTH bits: the registered selected data.
REQ-011 SHALL have port out_valid, output, 1 bit: result holds an unconsumed word.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream consumes result.
REQ-013 SHALL have port sel_err, output, 1 bit: sticky illegal-select flag.
REQ-014 SHALL have port err_clr, input, 1 bit: a synchronous clear of sel_err (and the error counter, if present).

Function
REQ-015 An accept SHALL occur on a rising edge when in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL be combinational: in_ready = !out_valid || out_ready.
REQ-017 On accept with sel < NUM_IN, result SHALL load input[sel] on that edge (latency 1 cycle).
REQ-018 On accept with sel >= NUM_IN, result SHALL load all zeros and sel_err SHALL set to 1 on that edge.
REQ-019 out_valid SHALL set to 1 on any accept, legal or illegal.
REQ-020 out_valid SHALL clear when out_valid=1, out_ready=1 and there is no accept in the same cycle.
REQ-021 With out_valid=1 and out_ready=0, result and out_valid SHALL hold, and data_in/sel changes SHALL be ignored.
REQ-022 A simultaneous consume and accept SHALL sustain 1 word per cycle: out_valid stays 1 and result takes the new word.
REQ-023 Outside an accept, result SHALL NOT change, including when data_in or sel change.
REQ-024 sel_err SHALL remain 1 until err_clr=1.
REQ-025 If err_clr=1 and an illegal accept occur on the same edge, sel_err SHALL end at 1 (set wins).
REQ-026 The block SHALL contain no combinational path from data_in or sel to result.

Reset
REQ-027 On reset assertion, result SHALL go immediately to 0, out_valid to 0 and sel_err to 0 (and err_cnt to 0, if present).
REQ-028 During reset, in_ready SHALL read 1 (out_valid=0); no accept SHALL occur while reset=1.
REQ-029 Reset during a stalled transfer SHALL discard the held word with no recovery.
REQ-030 The first accept SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-031 With macro BUS_MUX_PIPE_ERR_CNT_EN defined, the block SHALL add output err_cnt (8 bits) that counts illegal accepts.
REQ-032 err_cnt SHALL saturate at 255.
REQ-033 err_clr SHALL zero err_cnt; if err_clr and an illegal accept coincide, err_cnt SHALL become 1.
REQ-034 Without BUS_MUX_PIPE_ERR_CNT_EN, port err_cnt and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Defaults; inputs 0..4 = 8'h10,8'h21,8'h32,8'h43,8'h54; out_ready=1; sel=0..4 on consecutive cycles -> result 10,21,32,43,54, one cycle after each accept, out_valid continuously 1.
REQ-036 sel=3'd6 accepted -> result=8'h00, out_valid=1, sel_err=1; err_clr pulse -> sel_err=0.
REQ-037 out_ready=0 after accepting sel=2 -> in_ready=0; result stays 8'h32 while data_in and sel toggle; out_ready=1 -> one consume, then out_valid=0.
REQ-038 Reset asserted mid-cycle while out_valid=1 -> result=0 and out_valid=0 before the next edge; first post-reset accept of sel=1 -> 8'h21.
REQ-039 WIDTH=16, NUM_IN=9, SEL_W=4: sel=8 -> input 8 selected; sel=9 -> zero result and sel_err=1.
REQ-040 With BUS_MUX_PIPE_ERR_CNT_EN: 300 illegal accepts -> err_cnt=255; then err_clr together with an illegal accept -> err_cnt=1, sel_err=1.
